// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor built around a single 4-bit ripple-carry slice.
// One nibble is processed per clock, LSB nibble first, with a registered carry between passes.
module nibble_serial_adder #(
  parameter  int WIDTH   = 16,
  localparam int NIBBLES = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   sum_q;
  logic               cout_q;
  logic               ovf_q;
  logic               out_valid_q;

  logic [3:0]         slice_a_d;
  logic [3:0]         slice_b_d;
  logic [3:0]         slice_sum_d;
  logic               slice_co_d;
  logic               slice_c3_d;
  logic               last_pass_d;

  // Bit-level ripple through one nibble; returns {carry into bit 3, carry out, sum}.
  function automatic logic [5:0] slice_add(input logic [3:0] x, input logic [3:0] y,
                                           input logic ci);
    logic [4:0] c;
    logic [3:0] s;
    c[0] = ci;
    for (int k = 0; k < 4; k++) begin
      s[k]   = x[k] ^ y[k] ^ c[k];
      c[k+1] = (x[k] & y[k]) | (x[k] & c[k]) | (y[k] & c[k]);
    end
    return {c[3], c[4], s};
  endfunction

  // Select the current nibble of each operand and run it through the slice.
  always_comb begin
    slice_a_d   = a_q[{idx_q, 2'b00} +: 4];
    slice_b_d   = b_q[{idx_q, 2'b00} +: 4];
    {slice_c3_d, slice_co_d, slice_sum_d} = slice_add(slice_a_d, slice_b_d, carry_q);
    last_pass_d = (idx_q == IDX_W'(NIBBLES - 1));
  end

  // Sequencer: operand capture, nibble passes, result hold and handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + 1, so the inversion and forced carry happen here.
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            carry_q <= sub ? 1'b1 : cin;
            idx_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          sum_q[{idx_q, 2'b00} +: 4] <= slice_sum_d;
          carry_q                    <= slice_co_d;
          if (last_pass_d) begin
            cout_q      <= slice_co_d;
            ovf_q       <= slice_c3_d ^ slice_co_d;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign busy      = (state_q == S_RUN);
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed corner cases, backpressure,
// mid-operation reset and randomized operations against an integer arithmetic model.
module tb_nibble_serial_adder;

  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned for sum/cout and signed for overflow.
  task automatic ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                           input logic rcin, input logic rsub,
                           output logic [W-1:0] rs, output logic rc, output logic ro);
    int ua, ub, sa, sb, us, ss;
    ua = ra;
    ub = rb;
    sa = ra[W-1] ? ua - 65536 : ua;
    sb = rb[W-1] ? ub - 65536 : ub;
    if (rsub) begin
      us = ua - ub;
      ss = sa - sb;
      rc = (ua >= ub);
    end else begin
      us = ua + ub + int'(rcin);
      ss = sa + sb + int'(rcin);
      rc = (us > 65535);
    end
    rs = us[W-1:0];
    ro = (ss > 32767) || (ss < -32768);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation: accept, latency/busy check, hold under backpressure, handshake.
  task automatic do_op(input string tag, input logic [W-1:0] oa, input logic [W-1:0] ob,
                       input logic ocin, input logic osub, input int hold, input bit junk,
                       input logic [W-1:0] es, input logic ec, input logic eo);
    int wait_cnt, lat, busy_cnt;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 20) begin
      tick();
      wait_cnt++;
    end
    chk_eq({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    a = oa; b = ob; cin = ocin; sub = osub; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    while (!out_valid && lat < 20) begin
      if (busy) busy_cnt++;
      chk_eq({tag, ".run_in_ready"}, {31'd0, in_ready}, 32'd0);
      // Scramble inputs during RUN; only the accept edge may sample them.
      if (junk) begin
        a = W'($urandom); b = W'($urandom); sub = ~osub; cin = ~ocin; in_valid = 1'b1;
      end
      tick();
      lat++;
    end
    chk_eq({tag, ".latency"}, 32'(lat), 32'(N));
    chk_eq({tag, ".busy_cycles"}, 32'(busy_cnt), 32'(N));
    chk_eq({tag, ".sum"}, {16'd0, sum}, {16'd0, es});
    chk_eq({tag, ".cout"}, {31'd0, cout}, {31'd0, ec});
    chk_eq({tag, ".ovf"}, {31'd0, ovf}, {31'd0, eo});
    for (int i = 0; i < hold; i++) begin
      if (junk) begin
        a = W'($urandom); b = W'($urandom); in_valid = 1'b1;
      end
      tick();
      chk_eq({tag, ".hold_valid"}, {31'd0, out_valid}, 32'd1);
      chk_eq({tag, ".hold_sum"}, {16'd0, sum}, {16'd0, es});
      chk_eq({tag, ".hold_flags"}, {30'd0, cout, ovf}, {30'd0, ec, eo});
      chk_eq({tag, ".hold_in_ready"}, {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk_eq({tag, ".post_valid"}, {31'd0, out_valid}, 32'd0);
    chk_eq({tag, ".post_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [W-1:0] ra, rb, es;
    logic         rc, rs, ec, eo;
    int           hold, lat;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    tick();
    tick();
    chk_eq("rst.state", {27'd0, out_valid, busy, in_ready, cout, ovf}, 32'd0);
    chk_eq("rst.sum", {16'd0, sum}, 32'd0);
    rst = 1'b0;
    #1;
    chk_eq("rst.in_ready", {31'd0, in_ready}, 32'd1);

    do_op("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 0, 1'b0, 16'h5555, 1'b0, 1'b0);
    do_op("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("add_cin", 16'h0000, 16'h0000, 1'b1, 1'b0, 1, 1'b0, 16'h0001, 1'b0, 1'b0);
    do_op("add_ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("add_ovf_neg", 16'h8000, 16'h8000, 1'b0, 1'b0, 0, 1'b0, 16'h0000, 1'b1, 1'b1);
    do_op("sub_borrow", 16'h0005, 16'h0007, 1'b0, 1'b1, 0, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    do_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1, 0, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    do_op("backpressure", 16'hA5C3, 16'h1F0E, 1'b1, 1'b0, 5, 1'b1, 16'hC4D2, 1'b0, 1'b0);

    // Reset after two nibble passes of 0xAAAA + 0x5555.
    a = 16'hAAAA; b = 16'h5555; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk_eq("midrst.busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk_eq("midrst.in_ready_rst", {31'd0, in_ready}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk_eq("midrst.sum", {16'd0, sum}, 32'd0);
    chk_eq("midrst.flags", {29'd0, out_valid, busy, in_ready}, 32'd1);
    lat = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) lat++;
    end
    chk_eq("midrst.no_result", 32'(lat), 32'd0);
    do_op("after_rst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 0, 1'b0, 16'h0100, 1'b0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      case ($urandom_range(0, 3))
        0: ra = 16'hFFFF;
        1: rb = ra;
        default: ;
      endcase
      rc   = 1'($urandom);
      rs   = 1'($urandom);
      hold = $urandom_range(0, 3);
      ref_model(ra, rb, rc, rs, es, ec, eo);
      do_op($sformatf("rnd%0d", t), ra, rb, rc, rs, hold, 1'($urandom), es, ec, eo);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
